// File: rtl/psg_pkg.sv
// psg_pkg: shared constants and types for the PSG command controller.
//   CH_NOISE    - channel index of the noise generator
//   ATTEN_OFF   - attenuation value that silences a channel
//   psg_fsm_e   - command sequencer states
//   psg_latch_t - currently latched register target (channel + volume flag)
package psg_pkg;

    localparam logic [1:0] CH_NOISE  = 2'd3;
    localparam logic [3:0] ATTEN_OFF = 4'hF;

    typedef enum logic [1:0] {IDLE, EXEC, WAIT} psg_fsm_e;

    typedef struct packed {
        logic [1:0] chan;
        logic       vol;
    } psg_latch_t;

endpackage

// File: rtl/psg_cmd_fifo.sv
// psg_cmd_fifo: byte FIFO that queues PSG command writes.
// Ports:
//   clk, reset     - clock, synchronous active-high reset (empties FIFO)
//   push, wr_data  - write request and byte
//   pop            - consume head entry
//   rd_data        - head entry (valid while !empty)
//   full, empty    - occupancy flags
// A push while full is only accepted when a pop happens on the same edge.
module psg_cmd_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] wr_data,
    output logic [7:0] rd_data,
    output logic       full,
    output logic       empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;   // extra MSB distinguishes full from empty
    logic        wr_en, rd_en;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_en   = pop && !empty;
    assign wr_en   = push && (!full || rd_en);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/psg_cmd_ctrl.sv
// psg_cmd_ctrl: decodes CPU writes to the PSG port into tone, attenuation and
// noise registers, one command byte at a time, with a valid/ready change
// notification per byte.
// Ports:
//   clk, reset             - clock, synchronous active-high reset
//   addr, MREQ_N, WR_N,    - CPU bus; a write to PSG_ADDR queues one byte
//   data
//   freq[2:0]              - 10-bit tone period per channel
//   atten_mag[3:0]         - attenuation per channel (3 = noise)
//   enable[2:0]            - tone channel audible (attenuation not OFF)
//   noise_ctrl             - noise mode / shift rate
//   cfg_valid, cfg_ready,  - change notification handshake
//   cfg_chan, cfg_vol
//   noise_rst              - one-cycle pulse: reseed noise LFSR
//   overflow               - sticky: a byte was dropped on a full FIFO
//   busy                   - bytes pending or a command in flight
module psg_cmd_ctrl
    import psg_pkg::*;
#(
    parameter logic [15:0] PSG_ADDR   = 16'h007F,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [15:0]      addr,
    input  logic             MREQ_N,
    input  logic             WR_N,
    input  logic [7:0]       data,
    output logic [2:0][9:0]  freq,
    output logic [3:0][3:0]  atten_mag,
    output logic [2:0]       enable,
    output logic [2:0]       noise_ctrl,
    output logic             cfg_valid,
    input  logic             cfg_ready,
    output logic [1:0]       cfg_chan,
    output logic             cfg_vol,
    output logic             noise_rst,
    output logic             overflow,
    output logic             busy
);

    psg_fsm_e   state;
    psg_latch_t latch, nl;
    logic       wr_act, wr_act_q, push, pop, full, empty;
    logic [7:0] head, cmd_q;

    // Edge-detect the strobe so a long write pulse queues exactly one byte.
    assign wr_act = !MREQ_N && !WR_N && (addr == PSG_ADDR);
    assign push   = wr_act && !wr_act_q;
    assign pop    = (state == IDLE) && !empty;
    assign busy   = !empty || (state != IDLE);

    for (genvar c = 0; c < 3; c++) begin : g_en
        assign enable[c] = (atten_mag[c] != ATTEN_OFF);
    end

    psg_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .pop     (pop),
        .wr_data (data),
        .rd_data (head),
        .full    (full),
        .empty   (empty)
    );

    // Target of the byte being executed: a latch byte retargets before applying.
    always_comb begin
        nl = latch;
        if (cmd_q[7]) begin
            nl.chan = cmd_q[6:5];
            nl.vol  = cmd_q[4];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            latch      <= '0;
            cmd_q      <= '0;
            wr_act_q   <= 1'b0;
            freq       <= '0;
            atten_mag  <= {4{ATTEN_OFF}};
            noise_ctrl <= '0;
            cfg_valid  <= 1'b0;
            cfg_chan   <= '0;
            cfg_vol    <= 1'b0;
            noise_rst  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            wr_act_q  <= wr_act;
            noise_rst <= 1'b0;
            if (push && full && !pop) overflow <= 1'b1;

            case (state)
                IDLE: begin
                    if (!empty) begin
                        cmd_q <= head;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    latch     <= nl;
                    cfg_chan  <= nl.chan;
                    cfg_vol   <= nl.vol;
                    cfg_valid <= 1'b1;
                    state     <= WAIT;
                    if (nl.vol) begin
                        atten_mag[nl.chan] <= cmd_q[3:0];
                    end else if (nl.chan == CH_NOISE) begin
                        noise_ctrl <= cmd_q[2:0];
                        noise_rst  <= 1'b1;
                    end else if (cmd_q[7]) begin
                        freq[nl.chan][3:0] <= cmd_q[3:0];
                    end else begin
                        freq[nl.chan][9:4] <= cmd_q[5:0];
                    end
                end
                WAIT: begin
                    if (cfg_ready) begin
                        cfg_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
